// File: rtl/ucode_mul_seq_if.sv
// Decoder/register-file bus of the microcode multiply sequencer.
// The slave modport is the sequencer; master is the decoder plus register file.
interface ucode_mul_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
);
    logic              mul_trigger;
    logic [REG_AW-1:0] dest_reg;
    logic [REG_AW-1:0] src_reg;
    logic [DATA_W-1:0] imm;
    logic              rd_en;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              overflow;

    modport slave (
        input  mul_trigger, dest_reg, src_reg, imm, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, overflow
    );

    modport master (
        output mul_trigger, dest_reg, src_reg, imm, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, overflow
    );
endinterface

// File: rtl/ucode_mul_seq.sv
// Microcode multiply sequencer: reads a source register and multiplies it by an
// immediate with a shift-add loop, one multiplier bit per cycle, then writes the low half back.
module ucode_mul_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    ucode_mul_seq_if.slave    bus
);
    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {IDLE, READ, LOAD, MUL, WRITE} state_t;

    state_t            state_q, state_d;
    logic [REG_AW-1:0] dest_q, dest_d, src_q, src_d;
    logic [ACC_W-1:0]  mcand_q, mcand_d, acc_q, acc_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // State, datapath and output registers; reset aborts any operation without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            src_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            src_q     <= src_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state and datapath; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        src_d    = src_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.mul_trigger) begin
                    dest_d   = bus.dest_reg;
                    src_d    = bus.src_reg;
                    mplier_d = bus.imm;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = READ;
                end
            end
            READ:  state_d = LOAD;
            LOAD: begin
                mcand_d = ACC_W'(bus.rd_data);
                state_d = (mplier_q == '0) ? WRITE : MUL;
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (mplier_d == '0 || cnt_d == CNT_W'(DATA_W)) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        rd_en_d   = (state_d == READ);
        rd_addr_d = (state_d == READ) ? src_d : '0;
        wr_en_d   = (state_d == WRITE);
        done_d    = (state_d == WRITE);
        wr_addr_d = (state_d == WRITE) ? dest_d : '0;
        wr_data_d = (state_d == WRITE) ? acc_d[DATA_W-1:0] : '0;
        ovf_d     = (state_d == WRITE) ? (acc_d[ACC_W-1:DATA_W] != '0) : ovf_q;
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ucode_mul_seq.sv
// Directed bench for ucode_mul_seq: a table of multiply vectors run back to back,
// plus hand sequences for trigger-while-busy and reset mid-operation.
module tb_ucode_mul_seq;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;

    typedef struct {
        logic [REG_AW-1:0] src;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] exp_data;
        logic              exp_ovf;
        int                exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic              pl_en   = 1'b0;
    logic [REG_AW-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    logic [DATA_W-1:0] rf [16];
    logic [DATA_W-1:0] rd_q;

    ucode_mul_seq_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    ucode_mul_seq #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Register file model: synchronous read, write after read in the same edge.
    always @(posedge clk) begin
        if (pl_en)           rf[pl_addr]     <= pl_data;
        else if (bus.wr_en)  rf[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_en)       rd_q            <= rf[bus.rd_addr];
    end
    assign bus.rd_data = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge after the write.
    task automatic run_op(input vec_t v, input bit stray);
        int  cyc = 0;
        int  rd_cnt = 0;
        bit  found = 0;
        bit  busy_ok = 1;
        bus.mul_trigger = 1'b1;
        bus.src_reg     = v.src;
        bus.dest_reg    = v.dest;
        bus.imm         = v.imm;
        @(posedge clk);
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.mul_trigger = 1'b0;
                chk("rd_addr_cycle1", 32'(bus.rd_addr), 32'(v.src));
            end
            if (stray && c == 3) begin
                bus.mul_trigger = 1'b1; bus.dest_reg = 4'd7; bus.src_reg = 4'd0; bus.imm = 16'd3;
            end
            if (stray && c == 4) bus.mul_trigger = 1'b0;
            if (bus.rd_en) rd_cnt++;
            if (c == 1 && !bus.rd_en) rd_cnt = -100;
            if (!bus.busy) busy_ok = 0;
            if (bus.wr_en) begin
                found = 1;
                cyc   = c;
            end
        end
        chk("write_seen", 32'(found), 32'd1);
        chk("rd_en_only_cycle1", 32'(rd_cnt), 32'd1);
        chk("busy_through_write", 32'(busy_ok), 32'd1);
        chk("write_latency", 32'(cyc), 32'(v.exp_cyc));
        chk("wr_addr", 32'(bus.wr_addr), 32'(v.dest));
        chk("wr_data", 32'(bus.wr_data), 32'(v.exp_data));
        chk("done_with_write", 32'(bus.done), 32'd1);
        chk("overflow", 32'(bus.overflow), 32'(v.exp_ovf));
        @(negedge clk);
        chk("idle_after_write", {29'd0, bus.busy, bus.wr_en, bus.done}, 32'd0);
        chk("overflow_held", 32'(bus.overflow), 32'(v.exp_ovf));
    endtask

    vec_t vecs [7];
    vec_t v_basic, v_b2b, v_post;

    initial begin
        int wr_seen;
        bus.mul_trigger = 1'b0;
        bus.src_reg     = '0;
        bus.dest_reg    = '0;
        bus.imm         = '0;

        //            src    dest    imm        data       ovf  cycle
        vecs[0] = '{4'd2,  4'd5,  16'd6,     16'd42,    1'b0, 6};
        vecs[1] = '{4'd1,  4'd3,  16'd0,     16'd0,     1'b0, 3};
        vecs[2] = '{4'd4,  4'd8,  16'h0010,  16'h0000,  1'b1, 8};
        vecs[3] = '{4'd13, 4'd15, 16'd2,     16'd4,     1'b0, 5};
        vecs[4] = '{4'd9,  4'd10, 16'hFFFF,  16'h0001,  1'b1, 19};
        vecs[5] = '{4'd14, 4'd12, 16'h8000,  16'h8000,  1'b0, 19};
        vecs[6] = '{4'd6,  4'd6,  16'd9,     16'd81,    1'b0, 7};
        v_basic = '{4'd2,  4'd5,  16'd6,     16'd42,    1'b0, 6};
        v_b2b   = '{4'd1,  4'd7,  16'd2,     16'h2468,  1'b0, 5};
        v_post  = '{4'd11, 4'd0,  16'd5,     16'd15,    1'b0, 6};

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {19'd0, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.overflow}, 32'd0);
        chk("reset_wr_data", 32'(bus.wr_data), 32'd0);
        rst = 1'b1;

        preload(4'd2, 16'd7);
        preload(4'd1, 16'h1234);
        preload(4'd4, 16'h1000);
        preload(4'd13, 16'd2);
        preload(4'd9, 16'hFFFF);
        preload(4'd14, 16'd1);
        preload(4'd6, 16'd9);
        preload(4'd11, 16'd3);
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i], 1'b0);
        chk("rf6_self_write", 32'(rf[6]), 32'd81);

        // Trigger during MUL is dropped; a trigger right after the write is accepted.
        run_op(v_basic, 1'b1);
        run_op(v_b2b, 1'b0);
        @(negedge clk);
        chk("rf7_b2b_product", 32'(rf[7]), 32'h2468);

        // Asynchronous reset in the middle of MUL.
        bus.mul_trigger = 1'b1; bus.src_reg = 4'd2; bus.dest_reg = 4'd3; bus.imm = 16'd6;
        @(posedge clk);
        @(negedge clk) bus.mul_trigger = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_mid_outputs",
            {19'd0, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.overflow}, 32'd0);
        chk("reset_mid_wr_data", 32'(bus.wr_data), 32'd0);
        @(negedge clk) rst = 1'b1;
        wr_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.wr_en || bus.busy) wr_seen++;
        end
        chk("no_write_after_reset", 32'(wr_seen), 32'd0);
        chk("rf3_untouched", 32'(rf[3]), 32'd0);
        run_op(v_post, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
